// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory arbiter: command bytes, FSM states,
// requester encodings and the frame builder.
package spi_mem_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StTx,
    StRx,
    StDone
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

  // Command, address and data byte in transmit order; reads clock out zeros.
  function automatic logic [31:0] build_frame(input logic we, input logic [15:0] addr,
                                              input logic [7:0] wdata);
    return {(we ? CMD_WRITE : CMD_READ), addr, (we ? wdata : 8'h00)};
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 bit engine: clock divider, 32-bit frame shifter, bit counter
// and receive byte capture. One frame per start pulse.
module spi_shift_engine
  import spi_mem_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] frame,
  input  logic        is_read,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        bit_end,
  output logic [4:0]  bit_cnt,
  output logic        done,
  output logic [7:0]  rx_byte
);

  localparam int unsigned DivW = $clog2(CLK_DIV) + 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic            active_q;
  logic            sclk_q;
  logic            read_q;
  logic [DivW-1:0] div_q;
  logic [4:0]      bit_q;
  logic [31:0]     shreg_q;
  logic [7:0]      rx_q;
  logic            tick;
  logic            rise;

  // Half-period boundaries and the rising/falling events derived from them.
  always_comb begin
    tick    = active_q && (div_q == DivLast);
    rise    = tick && !sclk_q;
    bit_end = tick && sclk_q;
    done    = bit_end && (bit_q == 5'd0);
    bit_cnt = bit_q;
    sclk    = sclk_q;
    rx_byte = rx_q;
    // Shift register only moves on falling edges, so mosi is stable while sclk is high.
    mosi    = active_q && shreg_q[31] && !(read_q && (bit_q < 5'd8));
  end

  // Divider, sclk toggle, mosi shift on falling edge, miso capture on rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      read_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= 5'd0;
      shreg_q  <= 32'h0;
      rx_q     <= 8'h00;
    end else if (start) begin
      active_q <= 1'b1;
      sclk_q   <= 1'b0;
      read_q   <= is_read;
      div_q    <= '0;
      bit_q    <= 5'd31;
      shreg_q  <= frame;
      rx_q     <= 8'h00;
    end else if (active_q) begin
      if (tick) begin
        div_q  <= '0;
        sclk_q <= !sclk_q;
        if (rise && read_q && (bit_q < 5'd8)) begin
          rx_q <= {rx_q[6:0], miso};
        end
        if (bit_end) begin
          shreg_q <= {shreg_q[30:0], 1'b0};
          if (bit_q == 5'd0) begin
            active_q <= 1'b0;
          end else begin
            bit_q <= bit_q - 5'd1;
          end
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter between instruction fetch (ROM) and load/store (RAM)
// sharing one SPI bus; one command/address/data frame per grant.
module spi_mem_arbiter
  import spi_mem_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [7:0]  if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [7:0]  d_wdata,
  output logic [7:0]  d_rdata,
  output logic        d_ack,
  output logic        busy,
  output logic        sclk,
  output logic        cs_rom,
  output logic        cs_ram,
  output logic        mosi,
  input  logic        miso
);

  state_e      state_q, state_d;
  port_e       port_q;
  port_e       ptr_q;
  logic        we_q;
  logic [7:0]  if_rdata_q;
  logic [7:0]  d_rdata_q;

  logic        grant_if, grant_d, grant;
  logic [31:0] frame;
  logic        frame_read;
  logic        in_frame;

  logic        eng_bit_end;
  logic [4:0]  eng_bit_cnt;
  logic        eng_done;
  logic [7:0]  eng_rx_byte;

  spi_shift_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clk     (clk),
    .rst     (rst),
    .start   (grant),
    .frame   (frame),
    .is_read (frame_read),
    .miso    (miso),
    .sclk    (sclk),
    .mosi    (mosi),
    .bit_end (eng_bit_end),
    .bit_cnt (eng_bit_cnt),
    .done    (eng_done),
    .rx_byte (eng_rx_byte)
  );

  // Round-robin grant in IDLE; the pointer names the port preferred on a tie.
  always_comb begin
    grant_if   = (state_q == StIdle) && !rst && if_req && (!d_req || (ptr_q == PORT_IF));
    grant_d    = (state_q == StIdle) && !rst && d_req && (!if_req || (ptr_q == PORT_D));
    grant      = grant_if || grant_d;
    frame      = grant_if ? build_frame(1'b0, if_addr, 8'h00) : build_frame(d_we, d_addr, d_wdata);
    frame_read = grant_if || !d_we;
  end

  // Next-state: phases advance on the falling edge that closes each field.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (grant) state_d = StCmd;
      StCmd:  if (eng_bit_end && (eng_bit_cnt == 5'd24)) state_d = StAddr;
      StAddr: if (eng_bit_end && (eng_bit_cnt == 5'd8)) state_d = we_q ? StTx : StRx;
      StTx:   if (eng_done) state_d = StDone;
      StRx:   if (eng_done) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Chip selects, acks and busy decoded from the registered state.
  always_comb begin
    in_frame = (state_q == StCmd) || (state_q == StAddr) || (state_q == StTx) ||
               (state_q == StRx);
    cs_rom   = !(in_frame && (port_q == PORT_IF));
    cs_ram   = !(in_frame && (port_q == PORT_D));
    if_ack   = (state_q == StDone) && (port_q == PORT_IF);
    d_ack    = (state_q == StDone) && (port_q == PORT_D);
    busy     = (state_q != StIdle) || grant;
    if_rdata = if_rdata_q;
    d_rdata  = d_rdata_q;
  end

  // State, grant bookkeeping and read-data capture on the way into DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      port_q     <= PORT_IF;
      ptr_q      <= PORT_IF;
      we_q       <= 1'b0;
      if_rdata_q <= 8'h00;
      d_rdata_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      if (grant) begin
        port_q <= grant_if ? PORT_IF : PORT_D;
        ptr_q  <= grant_if ? PORT_D : PORT_IF;
        we_q   <= grant_if ? 1'b0 : d_we;
      end
      if (eng_done && !we_q) begin
        if (port_q == PORT_IF) begin
          if_rdata_q <= eng_rx_byte;
        end else begin
          d_rdata_q <= eng_rx_byte;
        end
      end
    end
  end

endmodule

// File: doc/spi_mem_arbiter.md
# spi_mem_arbiter

Shares the single SPI memory bus between the instruction-fetch port (ROM) and the load/store port (RAM). It arbitrates the two requesters round-robin and sequences one complete SPI mode-0 frame per grant: 8-bit command, 16-bit address, then 8 data bits. It returns read data with a one-cycle acknowledge. It sits between the CPU core's fetch/memory stages and the external SPI flash and SRAM pins.

## Interface
- `CLK_DIV`, default 1: SCLK half-period in `clk` cycles, ≥1.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `if_req` in 1: fetch request. Held with `if_addr` until `if_ack`.
- `if_addr` in 16: fetch address (ROM).
- `if_rdata` out 8: fetch read data. Valid with `if_ack`, held until the next fetch ack.
- `if_ack` out 1: one-cycle fetch-complete pulse.
- `d_req` in 1: data request. Held with `d_we`/`d_addr`/`d_wdata` until `d_ack`.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in 16: data address (RAM).
- `d_wdata` in 8: write data.
- `d_rdata` out 8: data read result. Valid with `d_ack`; unchanged by writes.
- `d_ack` out 1: one-cycle data-complete pulse.
- `busy` out 1: high from the grant cycle through the ack cycle.
- `sclk`, `cs_rom`, `cs_ram`, `mosi` out 1 each; `miso` in 1: SPI pins.

## Operation
- Reset values: `sclk`=0, `cs_rom`=1, `cs_ram`=1, `mosi`=0, `if_ack`=`d_ack`=0, `if_rdata`=`d_rdata`=0, `busy`=0, state IDLE, round-robin pointer = fetch-preferred.
- States: IDLE → CMD (8 bits) → ADDR (16 bits) → TX (write) or RX (read) (8 bits) → DONE → IDLE.
- **IDLE.** Sample requests.
  - Only one pending: grant it.
  - Both pending: grant the one not served last. After reset, fetch wins.
  - On grant: latch addr, wdata and we; set `busy`; flip the pointer to the other port.
  - Fetch grants always read from ROM (`cs_rom`). Data grants target RAM (`cs_ram`).
- **Frame.** Command byte is 0x03 for read, 0x02 for write. Address is sent MSB first. Write data is sent MSB first.
- **SPI mode 0.**
  - `mosi` changes only while `sclk` is low. `miso` is sampled on `sclk` rising.
  - Each bit is CLK_DIV cycles low, then CLK_DIV cycles high.
  - During RX, `mosi`=0 and received bits shift in MSB first. During TX, `miso` is ignored.
- **Chip select.** The selected CS is low for all of CMD/ADDR/TX/RX. The non-selected CS stays 1 throughout. `sclk` is 0 whenever CS is high.
- **DONE.**
  - CS high, `sclk` 0, `mosi` 0.
  - Pulse the granted port's ack for one cycle.
  - For reads, load that port's rdata register in the same cycle, so the value is visible with the ack.
- Requests are not sampled in CMD/ADDR/TX/RX/DONE. A requester wanting back-to-back service keeps `req` high. A requester that is finished must drop `req` in the cycle after ack.
- Request inputs changing mid-transaction have no effect; values are latched at grant.
- **Reset mid-transfer.** Abort on the next edge: all outputs return to reset values, no ack is issued, and the partial data is discarded.

## Timing
- Cycle 0: request sampled in IDLE (grant).
- Cycle 1: CS low, `mosi`=cmd bit 7, `sclk` 0.
- Rising `sclk` edge for bit k (k = 0..31) at cycle 1+CLK_DIV+2·CLK_DIV·k.
- The last bit ends at cycle 1+64·CLK_DIV. That cycle is DONE (ack high, CS high).
- Next grant is possible at cycle 2+64·CLK_DIV.
  - CLK_DIV=1: ack at cycle 65; throughput is one transaction per 66 cycles.
- CS is high for ≥2 cycles between frames (DONE + IDLE).
- Address/bit counters are 5-bit, counting down without wrap. The divider counter is width $clog2(CLK_DIV)+1.

## Structure
- Shared package `spi_mem_pkg` holds:
  - CMD_READ = 8'h03 and CMD_WRITE = 8'h02
  - state encodings (IDLE, CMD, ADDR, TX, RX, DONE)
  - port-select encoding (PORT_IF, PORT_D)
- One natural sub-module: `spi_shift_engine`.
  - Contains the CLK_DIV divider, 32-bit frame shift register, bit counter, and RX byte capture.
  - Interface: `start`/`frame[31:0]`/`is_read` in; `done`/`rx_byte` out.
  - The arbiter owns arbitration, CS select, acks and rdata registers.

## Test plan
- **Fetch read.** `if_req`, `if_addr`=0x1234; ROM model returns 0xA5 → `mosi` carries 0x03,0x12,0x34; `cs_rom` low cycles 1–64; `if_ack` at cycle 65 with `if_rdata`=0xA5; `cs_ram` stays 1.
- **Data write.** `d_we`=1, `d_addr`=0x00FF, `d_wdata`=0x3C → `cs_ram` frame 0x02,0x00,0xFF,0x3C; `d_ack` at 65; `d_rdata` unchanged (0).
- **Data read.** `d_addr`=0x8001; RAM model returns 0x5A → frame 0x03,0x80,0x01; `d_rdata`=0x5A with `d_ack`.
- **Contention.** Both `req` held from reset → grant order F,D,F,D. Ack pulses 66 cycles apart, alternating ports. No cycle has both CS low.
- **Reset mid-transfer.** Assert `rst` during ADDR → next cycle CS=1, `sclk`=0, `mosi`=0, no ack. A subsequent fetch from 0x0001 completes normally.
- **CLK_DIV=3.** Single fetch → `sclk` period 6 cycles; first rising edge at cycle 4; ack at cycle 193.
